// File: rtl/cprv_hazard_forward_unit_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cprv_hazard_forward_unit_if : pipeline bundle for the EX hazard/forward unit
// Rev 1.0
// ---------------------------------------------------------------------------
interface cprv_hazard_forward_unit_if #(
    parameter int DATA_WIDTH = 64,
    parameter int NUM_RS     = 2
);
    logic                         flush;
    logic [NUM_RS*5-1:0]          rs_addr_ex;
    logic [NUM_RS-1:0]            rs_used_ex;
    logic [NUM_RS*DATA_WIDTH-1:0] rs_data_id_ex;
    logic [6:0]                   opcode_mem;
    logic [4:0]                   rd_addr_mem;
    logic                         rd_en_mem;
    logic [DATA_WIDTH-1:0]        alu_out_mem;
    logic [6:0]                   opcode_wb;
    logic [4:0]                   rd_addr_wb;
    logic                         rd_en_wb;
    logic [DATA_WIDTH-1:0]        alu_out_wb;
    logic [DATA_WIDTH-1:0]        mem_data_wb;
    logic                         long_start_ex;
    logic [4:0]                   long_rd_ex;
    logic [NUM_RS*DATA_WIDTH-1:0] rs_data_ex;
    logic [NUM_RS-1:0]            fwd_mem;
    logic [NUM_RS-1:0]            fwd_wb;
    logic                         stall_ex;
    logic                         long_busy;
    logic                         long_done;
    logic [4:0]                   long_rd;

    modport master (
        output flush, rs_addr_ex, rs_used_ex, rs_data_id_ex,
               opcode_mem, rd_addr_mem, rd_en_mem, alu_out_mem,
               opcode_wb, rd_addr_wb, rd_en_wb, alu_out_wb, mem_data_wb,
               long_start_ex, long_rd_ex,
        input  rs_data_ex, fwd_mem, fwd_wb, stall_ex, long_busy, long_done, long_rd
    );

    modport slave (
        input  flush, rs_addr_ex, rs_used_ex, rs_data_id_ex,
               opcode_mem, rd_addr_mem, rd_en_mem, alu_out_mem,
               opcode_wb, rd_addr_wb, rd_en_wb, alu_out_wb, mem_data_wb,
               long_start_ex, long_rd_ex,
        output rs_data_ex, fwd_mem, fwd_wb, stall_ex, long_busy, long_done, long_rd
    );
endinterface
`default_nettype wire

// File: rtl/cprv_hazard_forward_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cprv_hazard_forward_unit : EX operand forwarding, load-use and long-op stalls
// Rev 1.0
// ---------------------------------------------------------------------------
module cprv_hazard_forward_unit #(
    parameter int DATA_WIDTH = 64,
    parameter int NUM_RS     = 2,
    parameter int LONG_LAT   = 34
) (
    input  logic                      clk,
    input  logic                      rst_n,
    cprv_hazard_forward_unit_if.slave bus
);
    localparam int               c_cnt_w    = $clog2(LONG_LAT) + 1;
    localparam logic [6:0]       c_op_load  = 7'b0000011;
    localparam logic [0:0]       c_st_idle  = 1'b0;
    localparam logic [0:0]       c_st_busy  = 1'b1;
    localparam logic [c_cnt_w-1:0] c_cnt_init = c_cnt_w'(LONG_LAT - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

    logic [0:0]                   r_state;
    logic [c_cnt_w-1:0]           r_cnt;
    logic [4:0]                   r_long_rd;
    logic [NUM_RS-1:0]            w_fwd_mem;
    logic [NUM_RS-1:0]            w_fwd_wb;
    logic [NUM_RS-1:0]            w_load_use;
    logic [NUM_RS-1:0]            w_long_dep;
    logic [NUM_RS*DATA_WIDTH-1:0] w_rs_data;
    logic                         w_busy;
    logic                         w_stall;

    assign w_busy  = (r_state == c_st_busy);
    assign w_stall = ((|w_load_use) || (w_busy && (bus.long_start_ex || (|w_long_dep))))
                     && !bus.flush;

    for (genvar gi = 0; gi < NUM_RS; gi++) begin : g_rs
        logic [4:0]            w_addr;
        logic                  w_match_mem;
        logic                  w_match_wb;
        logic                  w_mem_hit;
        logic                  w_wb_hit;
        logic [DATA_WIDTH-1:0] w_sel;
        logic                  r_hold_valid;
        logic [DATA_WIDTH-1:0] r_hold_data;

        assign w_addr      = bus.rs_addr_ex[5*gi +: 5];
        assign w_match_mem = bus.rd_en_mem && (bus.rd_addr_mem == w_addr) && (w_addr != 5'd0);
        assign w_match_wb  = bus.rd_en_wb  && (bus.rd_addr_wb  == w_addr) && (w_addr != 5'd0);
        // A matching load still in MEM has no data yet; it stalls instead of forwarding.
        assign w_mem_hit   = w_match_mem && (bus.opcode_mem != c_op_load);
        assign w_wb_hit    = !w_mem_hit && (w_match_wb || r_hold_valid);

        always_comb begin
            if (w_mem_hit) begin
                w_sel = bus.alu_out_mem;
            end else if (w_match_wb) begin
                w_sel = (bus.opcode_wb == c_op_load) ? bus.mem_data_wb : bus.alu_out_wb;
            end else if (r_hold_valid) begin
                w_sel = r_hold_data;
            end else begin
                w_sel = bus.rs_data_id_ex[DATA_WIDTH*gi +: DATA_WIDTH];
            end
        end

        assign w_rs_data[DATA_WIDTH*gi +: DATA_WIDTH] = w_sel;
        assign w_fwd_mem[gi]  = w_mem_hit;
        assign w_fwd_wb[gi]   = w_wb_hit;
        assign w_load_use[gi] = bus.rs_used_ex[gi] && w_match_mem && (bus.opcode_mem == c_op_load);
        assign w_long_dep[gi] = bus.rs_used_ex[gi] && (w_addr == r_long_rd) && (w_addr != 5'd0);

        // Capture WB-sourced operands while stalled so they survive WB retiring.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_hold_valid <= 1'b0;
                r_hold_data  <= '0;
            end else if (w_stall) begin
                r_hold_valid <= w_wb_hit;
                r_hold_data  <= w_sel;
            end else begin
                r_hold_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= c_st_idle;
            r_cnt     <= '0;
            r_long_rd <= 5'd0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (bus.long_start_ex && !w_stall && !bus.flush) begin
                        r_state   <= c_st_busy;
                        r_cnt     <= c_cnt_init;
                        r_long_rd <= bus.long_rd_ex;
                    end
                end
                c_st_busy: begin
                    if (bus.flush || (r_cnt == '0)) begin
                        r_state <= c_st_idle;
                    end else begin
                        r_cnt <= r_cnt - c_cnt_one;
                    end
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

    assign bus.rs_data_ex = w_rs_data;
    assign bus.fwd_mem    = w_fwd_mem;
    assign bus.fwd_wb     = w_fwd_wb;
    assign bus.stall_ex   = w_stall;
    assign bus.long_busy  = w_busy;
    assign bus.long_done  = w_busy && (r_cnt == '0);
    assign bus.long_rd    = r_long_rd;
endmodule
`default_nettype wire
